wordcount_xfer_sequencer: RTL and testbench

//  Sequences one word-count job over the AXI read and write masters. On kick it latches the job parameters.
//  It splits the input region into bounded read bursts on the reader ctrl interface,

---
 rtl/wordcount_xfer_sequencer_if.sv | 11 +
 rtl/wordcount_xfer_sequencer.sv | 153 +++++++++++++++
 tb/tb_wordcount_xfer_sequencer.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wordcount_xfer_sequencer_if.sv
// Transfer-control handshake between the sequencer and one AXI master
// (reader or writer): start pulse, done pulse, address and size.
interface wordcount_xfer_sequencer_if;
  logic        start;
  logic        done;
  logic [63:0] addr_offset;
  logic [63:0] xfer_size_in_bytes;

  modport master (output start, output addr_offset, output xfer_size_in_bytes, input done);
  modport slave  (input start, input addr_offset, input xfer_size_in_bytes, output done);
endinterface

// File: rtl/wordcount_xfer_sequencer.sv
// Sequences one word-count job: the input region is split into bounded
// read bursts on the reader port, then one write of the result region is
// issued on the writer port. All outputs are registered.
module wordcount_xfer_sequencer #(
  parameter int unsigned WORD_BYTES      = 8,
  parameter int unsigned MAX_CHUNK_BYTES = 16384,
  parameter int unsigned ADDR_ALIGN      = 64
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              kick_i,
  output logic                              busy_o,
  output logic                              done_o,
  input  logic [31:0]                       command_i,
  input  logic [31:0]                       num_of_words_i,
  input  logic [63:0]                       global_memory_offset_i,
  input  logic [31:0]                       result_bytes_i,
  output logic [31:0]                       chunk_count_o,
  wordcount_xfer_sequencer_if.master        rd_ctrl,
  wordcount_xfer_sequencer_if.master        wr_ctrl
);

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, FIN} state_t;

  localparam logic [63:0] CHUNK_MAX  = 64'(MAX_CHUNK_BYTES);
  localparam logic [63:0] ALIGN_MASK = 64'(ADDR_ALIGN) - 64'd1;

  state_t      state_q;
  logic [1:0]  cmd_q;
  logic [31:0] res_q;
  logic [63:0] wr_base_q;
  logic [63:0] rd_remain_q;   // bytes left to read, including the chunk in flight
  logic [63:0] rd_addr_q;
  logic [63:0] rd_size_q;
  logic        rd_start_q;
  logic [63:0] wr_addr_q;
  logic [63:0] wr_size_q;
  logic        wr_start_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] chunk_q;

  logic [63:0] rd_total_d;
  logic [63:0] wr_base_d;
  logic [63:0] rd_remain_d;
  logic [63:0] rd_addr_d;
  logic        unused_cmd;

  // Job geometry from the live inputs (used at kick) and the advance of
  // the read cursor once the outstanding chunk completes.
  assign rd_total_d  = 64'(num_of_words_i) * 64'(WORD_BYTES);
  assign wr_base_d   = (global_memory_offset_i + rd_total_d + ALIGN_MASK) & ~ALIGN_MASK;
  assign rd_remain_d = rd_remain_q - rd_size_q;
  assign rd_addr_d   = rd_addr_q + rd_size_q;
  assign unused_cmd  = ^command_i[31:2];

  function automatic logic [63:0] clip_chunk(input logic [63:0] r);
    return (r > CHUNK_MAX) ? CHUNK_MAX : r;
  endfunction

  assign rd_ctrl.start              = rd_start_q;
  assign rd_ctrl.addr_offset        = rd_addr_q;
  assign rd_ctrl.xfer_size_in_bytes = rd_size_q;
  assign wr_ctrl.start              = wr_start_q;
  assign wr_ctrl.addr_offset        = wr_addr_q;
  assign wr_ctrl.xfer_size_in_bytes = wr_size_q;
  assign busy_o                     = busy_q;
  assign done_o                     = done_q;
  assign chunk_count_o              = chunk_q;

  // Job FSM; start pulses are set on entry to an ISSUE state so they line
  // up with it, done/busy-clear are set from FIN so they show the cycle after.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      res_q       <= '0;
      wr_base_q   <= '0;
      rd_remain_q <= '0;
      rd_addr_q   <= '0;
      rd_size_q   <= '0;
      rd_start_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_size_q   <= '0;
      wr_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      chunk_q     <= '0;
    end else begin
      rd_start_q <= 1'b0;
      wr_start_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (kick_i) begin
            cmd_q       <= command_i[1:0];
            res_q       <= result_bytes_i;
            wr_base_q   <= wr_base_d;
            rd_remain_q <= rd_total_d;
            chunk_q     <= '0;
            busy_q      <= 1'b1;
            if (command_i[0] && (rd_total_d != 64'd0)) begin
              rd_addr_q  <= global_memory_offset_i;
              rd_size_q  <= clip_chunk(rd_total_d);
              rd_start_q <= 1'b1;
              state_q    <= RD_ISSUE;
            end else if (command_i[1] && (result_bytes_i != 32'd0)) begin
              wr_addr_q  <= wr_base_d;
              wr_size_q  <= 64'(result_bytes_i);
              wr_start_q <= 1'b1;
              state_q    <= WR_ISSUE;
            end else begin
              state_q <= FIN;
            end
          end
        end
        RD_ISSUE: state_q <= RD_WAIT;
        RD_WAIT: begin
          if (rd_ctrl.done) begin
            chunk_q     <= chunk_q + 32'd1;
            rd_remain_q <= rd_remain_d;
            if (rd_remain_d == 64'd0) begin
              if (cmd_q[1] && (res_q != 32'd0)) begin
                wr_addr_q  <= wr_base_q;
                wr_size_q  <= 64'(res_q);
                wr_start_q <= 1'b1;
                state_q    <= WR_ISSUE;
              end else begin
                state_q <= FIN;
              end
            end else begin
              rd_addr_q  <= rd_addr_d;
              rd_size_q  <= clip_chunk(rd_remain_d);
              rd_start_q <= 1'b1;
              state_q    <= RD_ISSUE;
            end
          end
        end
        WR_ISSUE: state_q <= WR_WAIT;
        WR_WAIT: begin
          if (wr_ctrl.done) state_q <= FIN;
        end
        FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wordcount_xfer_sequencer.sv
// Bench for wordcount_xfer_sequencer: a table of directed jobs with
// hand-computed results, a few multi-cycle corner sequences, and random
// jobs checked against a queue-based reference model.
module tb_wordcount_xfer_sequencer;

  typedef struct {
    bit          is_wr;
    logic [63:0] addr;
    logic [63:0] size;
  } xfer_t;

  typedef struct {
    logic [1:0]  cmd;
    logic [31:0] words;
    logic [63:0] base;
    logic [31:0] res;
    int          n_rd;
    logic [63:0] rd_last_addr;
    logic [63:0] rd_last_size;
    bit          has_wr;
    logic [63:0] wr_addr;
    logic [63:0] wr_size;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        kick = 1'b0;
  logic        busy, done;
  logic [31:0] command = '0;
  logic [31:0] num_of_words = '0;
  logic [63:0] base = '0;
  logic [31:0] result_bytes = '0;
  logic [31:0] chunk_count;

  wordcount_xfer_sequencer_if rd_if();
  wordcount_xfer_sequencer_if wr_if();

  wordcount_xfer_sequencer dut (
    .clk                    (clk),
    .reset                  (reset),
    .kick_i                 (kick),
    .busy_o                 (busy),
    .done_o                 (done),
    .command_i              (command),
    .num_of_words_i         (num_of_words),
    .global_memory_offset_i (base),
    .result_bytes_i         (result_bytes),
    .chunk_count_o          (chunk_count),
    .rd_ctrl                (rd_if.master),
    .wr_ctrl                (wr_if.master)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  xfer_t obs_q[$];
  xfer_t exp_q[$];
  int    kick_cyc, done_at, last_in;
  bit    timed_out, busy_bad, timing_bad, overlap_bad;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic kick_job(input logic [1:0] c, input logic [31:0] w, input logic [63:0] b,
                          input logic [31:0] r, input bit hold);
    command      = {$urandom() & 32'hffff_fffc} | {30'd0, c};
    num_of_words = w;
    base         = b;
    result_bytes = r;
    kick         = 1'b1;
    kick_cyc     = cyc;
    step();
    if (!hold) kick = 1'b0;
  endtask

  // Acts as both masters: records each start, answers with a done pulse
  // 1..4 cycles later, and runs until the job done pulse or the budget.
  task automatic service(input int budget, input int prev_evt);
    int  rcnt = 0, wcnt = 0;
    bit  rout = 0, wout = 0;
    int  prev = prev_evt;
    obs_q.delete();
    done_at = -1; last_in = -1; timed_out = 1'b1;
    busy_bad = 0; timing_bad = 0; overlap_bad = 0;
    for (int i = 0; i < budget; i++) begin
      rd_if.done = 1'b0;
      wr_if.done = 1'b0;
      if (done) begin
        done_at   = cyc;
        timed_out = 1'b0;
        chk("busy_low_at_done", busy, 1'b0);
        break;
      end
      if (!busy) busy_bad = 1;
      if (rout) begin
        rcnt--;
        if (rcnt == 0) begin rd_if.done = 1'b1; rout = 0; last_in = cyc; prev = cyc; end
      end
      if (wout) begin
        wcnt--;
        if (wcnt == 0) begin wr_if.done = 1'b1; wout = 0; last_in = cyc; prev = cyc; end
      end
      if (rd_if.start || wr_if.start) begin
        if (rout || wout || (rd_if.start && wr_if.start)) overlap_bad = 1;
        if (cyc != prev + 1) timing_bad = 1;
      end
      if (rd_if.start) begin
        obs_q.push_back('{1'b0, rd_if.addr_offset, rd_if.xfer_size_in_bytes});
        rout = 1; rcnt = $urandom_range(1, 4);
      end
      if (wr_if.start) begin
        obs_q.push_back('{1'b1, wr_if.addr_offset, wr_if.xfer_size_in_bytes});
        wout = 1; wcnt = $urandom_range(1, 4);
      end
      step();
    end
    rd_if.done = 1'b0;
    wr_if.done = 1'b0;
    chk("timeout", timed_out, 1'b0);
    chk("busy_during_job", busy_bad, 1'b0);
    chk("start_timing", timing_bad, 1'b0);
    chk("overlap", overlap_bad, 1'b0);
    chk("done_latency", done_at, ((last_in < 0) ? kick_cyc : last_in) + 2);
  endtask

  // Reference: walk the region in MAX-sized steps, then align the result base up.
  task automatic build_model(input logic [1:0] c, input logic [31:0] w, input logic [63:0] b,
                             input logic [31:0] r);
    logic [63:0] remain, addr, sz, top;
    exp_q.delete();
    remain = 64'(w) * 64'd8;
    top    = b + remain;
    addr   = b;
    if (c[0]) begin
      while (remain != 0) begin
        sz = (remain < 64'd16384) ? remain : 64'd16384;
        exp_q.push_back('{1'b0, addr, sz});
        addr   = addr + sz;
        remain = remain - sz;
      end
    end
    if (c[1] && r != 0) begin
      top = top + ((64'd64 - (top % 64'd64)) % 64'd64);
      exp_q.push_back('{1'b1, top, 64'(r)});
    end
  endtask

  task automatic compare_model(input string tag);
    int nrd = 0;
    chk({tag, "_nxfer"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk({tag, "_kind"}, obs_q[i].is_wr, exp_q[i].is_wr);
      chk({tag, "_addr"}, obs_q[i].addr, exp_q[i].addr);
      chk({tag, "_size"}, obs_q[i].size, exp_q[i].size);
    end
    foreach (exp_q[i]) if (!exp_q[i].is_wr) nrd++;
    chk({tag, "_chunks"}, chunk_count, nrd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[$];
    int   quiet_bad;
    logic [63:0] rb;

    rd_if.done = 1'b0;
    wr_if.done = 1'b0;
    vt.push_back('{2'd1, 32'd4096, 64'h1000, 32'd0,   2, 64'h5000, 64'd16384, 1'b0, 64'h0,  64'h0});
    vt.push_back('{2'd3, 32'd3,    64'h40,   32'd256, 1, 64'h40,   64'd24,    1'b1, 64'h80, 64'd256});
    vt.push_back('{2'd0, 32'd10,   64'h100,  32'd64,  0, 64'h0,    64'h0,     1'b0, 64'h0,  64'h0});
    vt.push_back('{2'd1, 32'd0,    64'h100,  32'd64,  0, 64'h0,    64'h0,     1'b0, 64'h0,  64'h0});
    vt.push_back('{2'd2, 32'd5,    64'h10,   32'd64,  0, 64'h0,    64'h0,     1'b1, 64'h40, 64'd64});
    vt.push_back('{2'd1, 32'd2049, 64'h0,    32'd0,   2, 64'h4000, 64'd8,     1'b0, 64'h0,  64'h0});
    vt.push_back('{2'd3, 32'd1,    64'hffff_ffff_ffff_fff8, 32'd8, 1, 64'hffff_ffff_ffff_fff8, 64'd8, 1'b1, 64'h0, 64'd8});
    vt.push_back('{2'd3, 32'd2,    64'h0,    32'd0,   1, 64'h0,    64'd16,    1'b0, 64'h0,  64'h0});

    // Reset state
    repeat (3) step();
    chk("reset_busy_done", {busy, done}, 2'b00);
    chk("reset_starts", {rd_if.start, wr_if.start}, 2'b00);
    chk("reset_rd_addr", rd_if.addr_offset | rd_if.xfer_size_in_bytes, 64'd0);
    chk("reset_wr_addr", wr_if.addr_offset | wr_if.xfer_size_in_bytes, 64'd0);
    chk("reset_chunks", chunk_count, 32'd0);
    reset = 1'b0;
    step();

    // Directed table
    foreach (vt[k]) begin
      int          nrd;
      bit          has_wr;
      logic [63:0] la, ls, wa, ws;
      kick_job(vt[k].cmd, vt[k].words, vt[k].base, vt[k].res, 1'b0);
      service(400, kick_cyc);
      nrd = 0; has_wr = 0; la = 0; ls = 0; wa = 0; ws = 0;
      foreach (obs_q[i]) begin
        if (obs_q[i].is_wr) begin has_wr = 1; wa = obs_q[i].addr; ws = obs_q[i].size; end
        else begin nrd++; la = obs_q[i].addr; ls = obs_q[i].size; end
      end
      chk($sformatf("vec%0d_nrd", k), nrd, vt[k].n_rd);
      chk($sformatf("vec%0d_rd_last_addr", k), la, vt[k].rd_last_addr);
      chk($sformatf("vec%0d_rd_last_size", k), ls, vt[k].rd_last_size);
      chk($sformatf("vec%0d_has_wr", k), has_wr, vt[k].has_wr);
      chk($sformatf("vec%0d_wr_addr", k), wa, vt[k].wr_addr);
      chk($sformatf("vec%0d_wr_size", k), ws, vt[k].wr_size);
      chk($sformatf("vec%0d_chunks", k), chunk_count, vt[k].n_rd);
      step();
    end

    // Kick held high through a job: single transfer, then an immediate restart
    kick_job(2'd1, 32'd3, 64'h200, 32'd0, 1'b1);
    service(100, kick_cyc);
    chk("hold_first_nxfer", obs_q.size(), 1);
    step();
    kick = 1'b0;
    chk("hold_restart_start", rd_if.start, 1'b1);
    kick_cyc = done_at;
    service(100, done_at);
    chk("hold_second_nxfer", obs_q.size(), 1);
    if (obs_q.size() > 0) chk("hold_second_addr", obs_q[0].addr, 64'h200);

    // Stray master done pulses while idle
    quiet_bad = 0;
    rd_if.done = 1'b1; step(); rd_if.done = 1'b0;
    wr_if.done = 1'b1; step(); wr_if.done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (busy || done || rd_if.start || wr_if.start) quiet_bad++;
      step();
    end
    chk("stray_done_ignored", quiet_bad, 0);

    // Reset while a read is outstanding, then a late reader done
    kick_job(2'd1, 32'd4096, 64'h1000, 32'd0, 1'b0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midreset_outs", {busy, done, rd_if.start, wr_if.start}, 4'b0000);
    chk("midreset_rd", rd_if.addr_offset | rd_if.xfer_size_in_bytes, 64'd0);
    chk("midreset_chunks", chunk_count, 32'd0);
    rd_if.done = 1'b1; step(); rd_if.done = 1'b0;
    quiet_bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (busy || done || rd_if.start || wr_if.start) quiet_bad++;
      step();
    end
    chk("late_done_ignored", quiet_bad, 0);
    kick_job(2'd1, 32'd4096, 64'h1000, 32'd0, 1'b0);
    service(400, kick_cyc);
    build_model(2'd1, 32'd4096, 64'h1000, 32'd0);
    compare_model("restart");
    step();

    // Random jobs against the reference model
    for (int j = 0; j < 30; j++) begin
      logic [1:0]  c;
      logic [31:0] w, r;
      c  = 2'($urandom_range(0, 3));
      w  = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 40000));
      rb = {$urandom(), $urandom()};
      if ($urandom_range(0, 3) == 0) rb = 64'hffff_ffff_ffff_ff00 | 64'($urandom_range(0, 255));
      r  = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 4096));
      kick_job(c, w, rb, r, 1'b0);
      service(1000, kick_cyc);
      build_model(c, w, rb, r);
      compare_model($sformatf("rand%0d", j));
      repeat ($urandom_range(0, 2)) step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
